// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the VGA timing generator. Holds the
//               default 640x480@60 timing, the derived line/frame totals and
//               the position counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Width of the horizontal and vertical position counters
  localparam int CNT_W     = 10;
  // Largest line or frame total that the counter width can represent
  localparam int MAX_TOTAL = 1 << CNT_W;

  // Default horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Sum of the four timing intervals of one axis
  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : Wrapping position counter with enable. Counts 0..MODULUS-1
//               and flags the last value with a terminal-count output.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Terminal count: the counter sits on its last value
  assign tc = (count == LAST);

  // Advance on enable, wrapping to zero after the last value
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : VGA raster timing generator. Internal h/v counters advance on
//               pix_ce; all outputs are registered decodes of the counters
//               and lag them by exactly one pix_ce cycle.
//               Optional macro VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame
//               counter output (frame_cnt) aligned with the other outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic             clk_pix,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Totals beyond the counter range cannot be represented; stop elaboration
  generate
    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_err
      $error("vga_timing: H_TOTAL exceeds counter range");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_err
      $error("vga_timing: V_TOTAL exceeds counter range");
    end
  endgenerate

  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_h_tc;
  logic             w_v_tc;
  logic             w_de;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             r_at_origin;

  vga_axis_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (H_TOTAL)
  ) u_h_cnt (
    .clk   (clk_pix),
    .reset (reset),
    .en    (pix_ce),
    .count (w_h),
    .tc    (w_h_tc)
  );

  // The vertical counter steps only when the line wraps
  vga_axis_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (V_TOTAL)
  ) u_v_cnt (
    .clk   (clk_pix),
    .reset (reset),
    .en    (pix_ce & w_h_tc),
    .count (w_v),
    .tc    (w_v_tc)
  );

  assign w_de     = (w_h < H_ACT_END) && (w_v < V_ACT_END);
  assign w_hs_act = (w_h >= H_SYNC_LO) && (w_h <= H_SYNC_HI);
  assign w_vs_act = (w_v >= V_SYNC_LO) && (w_v <= V_SYNC_HI);

  // Tracks that the counters sit on (0,0); avoids a wide compare of both axes
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_at_origin <= 1'b1;
    end else if (pix_ce) begin
      r_at_origin <= w_h_tc & w_v_tc;
    end
  end

  // Register the decode of the current counter position on every pixel step
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hcount      <= w_h;
      vcount      <= w_v;
      de          <= w_de;
      hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      line_start  <= (w_h == '0);
      frame_start <= r_at_origin;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic r_started;

  // Frame index: 0 for the first frame after reset, then +1 per frame start
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      frame_cnt <= '0;
      r_started <= 1'b0;
    end else if (pix_ce && r_at_origin) begin
      frame_cnt <= r_started ? frame_cnt + 8'd1 : 8'd0;
      r_started <= 1'b1;
    end
  end
`else
  // No frame counter in this build
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing. Drives a small-timing
//               instance (active-high syncs) and a default 640x480 instance
//               from the same stimulus and compares both against a pixel-
//               index reference model every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;

  always #5 clk = ~clk;

  // Small instance outputs
  logic [9:0] s_hc, s_vc;
  logic       s_de, s_hs, s_vs, s_ls, s_fs;
  logic [7:0] s_fc;
  // Default instance outputs
  logic [9:0] d_hc, d_vc;
  logic       d_de, d_hs, d_vs, d_ls, d_fs;
  logic [7:0] d_fc;

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s (
    .clk_pix(clk), .reset(reset), .pix_ce(pix_ce),
    .hcount(s_hc), .vcount(s_vc), .de(s_de), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing dut_d (
    .clk_pix(clk), .reset(reset), .pix_ce(pix_ce),
    .hcount(d_hc), .vcount(d_vc), .de(d_de), .hsync(d_hs), .vsync(d_vs),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign s_fc = 8'd0;
  assign d_fc = 8'd0;
`endif

  // Timing of each instance: index 0 = small, index 1 = default
  int HA[2] = '{8, 640};
  int HF[2] = '{2, 16};
  int HS[2] = '{3, 96};
  int HT[2] = '{15, 800};
  int VA[2] = '{6, 480};
  int VF[2] = '{1, 10};
  int VS[2] = '{2, 2};
  int VT[2] = '{10, 525};
  bit HP[2] = '{1'b1, 1'b0};
  bit VP[2] = '{1'b1, 1'b0};

  // Reference model: linear pixel index within the frame being presented
  int n[2];
  bit valid[2];
  int fidx[2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit ce);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        valid[k] = 1'b0;
        n[k]     = 0;
        fidx[k]  = 0;
      end else if (ce) begin
        if (!valid[k]) begin
          valid[k] = 1'b1;
          n[k]     = 0;
          fidx[k]  = 0;
        end else begin
          n[k] = (n[k] + 1) % (HT[k] * VT[k]);
          if (n[k] == 0) fidx[k] = (fidx[k] + 1) % 256;
        end
      end
    end
  endtask

  task automatic compare_dut(input int k, input string nm, input logic [9:0] oh, input logic [9:0] ov,
                             input logic ode, input logic ohs, input logic ovs, input logic ols,
                             input logic ofs, input logic [7:0] ofc);
    int h, v;
    bit e_de, e_hs, e_vs, e_ls, e_fs;
    h    = valid[k] ? n[k] % HT[k] : 0;
    v    = valid[k] ? n[k] / HT[k] : 0;
    e_de = valid[k] && h < HA[k] && v < VA[k];
    e_hs = (valid[k] && h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k]) ? HP[k] : !HP[k];
    e_vs = (valid[k] && v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k]) ? VP[k] : !VP[k];
    e_ls = valid[k] && h == 0;
    e_fs = valid[k] && n[k] == 0;
    chk({nm, ".hcount"}, 32'(oh), 32'(h));
    chk({nm, ".vcount"}, 32'(ov), 32'(v));
    chk({nm, ".de"}, 32'(ode), 32'(e_de));
    chk({nm, ".hsync"}, 32'(ohs), 32'(e_hs));
    chk({nm, ".vsync"}, 32'(ovs), 32'(e_vs));
    chk({nm, ".line_start"}, 32'(ols), 32'(e_ls));
    chk({nm, ".frame_start"}, 32'(ofs), 32'(e_fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk({nm, ".frame_cnt"}, 32'(ofc), 32'(fidx[k]));
`else
    if (ofc !== 8'd0) chk({nm, ".frame_cnt_tie"}, 32'(ofc), 32'd0);
`endif
  endtask

  // One clock: apply inputs, advance the model at the edge, compare half a cycle later
  task automatic step(input bit rst, input bit ce);
    reset  = rst;
    pix_ce = ce;
    @(posedge clk);
    model_step(rst, ce);
    @(negedge clk);
    compare_dut(0, "s", s_hc, s_vc, s_de, s_hs, s_vs, s_ls, s_fs, s_fc);
    compare_dut(1, "d", d_hc, d_vc, d_de, d_hs, d_vs, d_ls, d_fs, d_fc);
  endtask

  initial begin
    int guard;
    reset  = 1'b1;
    pix_ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; valid[k] = 1'b0; fidx[k] = 0;
    end
    @(negedge clk);

    // Reset held with pix_ce high, then free-run across several lines/frames
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 2500; i++) step(1'b0, 1'b1);

    // Alternating clock-enable: outputs must hold on the idle cycles
    for (int i = 0; i < 600; i++) step(1'b0, (i % 2) == 0);

    // Mid-frame reset on the small instance at (h=5, v=3), held 3 cycles
    guard = 0;
    while ((n[0] != 3 * HT[0] + 5) && guard < 400) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk("reach_mid_frame", 32'(n[0]), 32'(3 * HT[0] + 5));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1);

    // Randomised clock-enable with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch (line total 800).
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (frame total 525).
  HSYNC_POL 0 hsync asserted level; VSYNC_POL 0 vsync asserted level.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
  clk_pix  in  1  pixel clock, single clock domain.
  reset  in  1  synchronous, active-high reset.
  pix_ce  in  1  pixel clock-enable; counters advance only when high.
  hcount  out  10  horizontal position, 0..H_TOTAL-1.
  vcount  out  10  vertical position, 0..V_TOTAL-1.
  de  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE.
  hsync  out  1  horizontal sync, at level HSYNC_POL when asserted.
  vsync  out  1  vertical sync, at level VSYNC_POL when asserted.
  line_start  out  1  one-ce pulse at hcount==0.
  frame_start  out  1  one-ce pulse at hcount==0 and vcount==0.
REQ-003 Single clock: clk_pix; synchronous active-high reset: reset.

Function
REQ-004 Internal counters h, v: h increments per pix_ce; at H_TOTAL-1, h wraps to 0 and v increments; at v==V_TOTAL-1 with h wrap, v wraps to 0.
REQ-005 All outputs are registered decodes of (h, v), updated only on pix_ce cycles, and mutually aligned: hcount/vcount/de/hsync/vsync/pulses always describe the same pixel.
REQ-006 Latency: outputs lag the internal counters by exactly one pix_ce cycle.
REQ-007 hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else at the inverse of HSYNC_POL.
REQ-008 vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], across the whole line, else inverse of VSYNC_POL.
REQ-009 pix_ce low: all outputs and counters hold; line_start/frame_start hold at their previous value; consumers qualify them with pix_ce.
REQ-010 H_TOTAL and V_TOTAL shall each be <=1024; violation is an elaboration error.

Reset
REQ-011 While reset is high: h=0, v=0, hcount=0, vcount=0, de=0, line_start=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-012 The first pix_ce after reset deasserts presents pixel (0,0): de=1, line_start=1, frame_start=1.
REQ-013 Reset mid-frame takes priority over pix_ce; the next frame restarts at (0,0) with no partial-line residue.

Configuration
REQ-014 Macro VGA_TIMING_FRAME_CNT_EN: when defined, adds output frame_cnt [7:0], reset to 0, incremented on every pix_ce that presents frame_start=1, wrapping 255->0, aligned with the other outputs; when undefined, the port and counter are absent.

Structure
REQ-015 Shared package vga_pkg holds the default 640x480@60 timing constants, the derived H_TOTAL/V_TOTAL, and the counter width (10).
REQ-016 One sub-module, vga_axis_counter (wrapping counter with enable, terminal-count output), is instantiated twice: once for h and once for v.

Verification
REQ-017 Reset with pix_ce=1, release -> first output cycle hcount=0, vcount=0, de=1, line_start=1, frame_start=1.
REQ-018 Free-run with pix_ce=1 -> hsync low for hcount 656..751 only; line period 800 clocks; de high for hcount 0..639.
REQ-019 Free-run -> vsync low for vcount 490..491 only; frame period 420000 clocks; de never high for vcount>=480.
REQ-020 pix_ce toggling 1,0,1,0 -> every output is stable on ce=0 cycles; frame period 840000 clk_pix cycles.
REQ-021 Assert reset at (hcount=300, vcount=200) for 3 cycles -> outputs return to reset values; the next ce gives (0,0) with frame_start=1.
REQ-022 With VGA_TIMING_FRAME_CNT_EN, run 257 frames -> frame_cnt sequence 0..255,0, incrementing on the frame_start cycle.
